exec_trace_tx: RTL and testbench

- FPGA-side trace transmitter for the 3-bit-PC processor core.
- Captures one {pc, flags, result} record each time the core signals a step.
- Buffers records in a small FIFO and serialises them out over a UART TX line (8N1) to a host.
- Sits beside the core in the board-level top and consumes the core's pc/flags/result outputs without back-pressuring the core.

---
 rtl/trace_pkg.sv | 26 ++
 rtl/trace_fifo.sv | 49 ++++
 rtl/exec_trace_tx.sv | 142 ++++++++++++++
 tb/tb_exec_trace_tx.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/trace_pkg.sv
// Shared types and constants for the execution-trace UART transmitter.
package trace_pkg;

    typedef struct packed {
        logic [2:0] pc;
        logic [1:0] flags;
        logic [3:0] result;
    } trace_rec_t;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        STOP   = 3'd3,
        PARITY = 3'd4
    } tx_state_t;

    localparam logic [2:0] SYNC_TAG = 3'b101;
    localparam logic       TX_IDLE  = 1'b1;

    // byte0 carries the sync tag so the host can re-align on record boundaries
    function automatic logic [7:0] rec_byte(input trace_rec_t rec, input logic sel);
        return sel ? {4'b0000, rec.result} : {SYNC_TAG, rec.pc, rec.flags};
    endfunction

endpackage

// File: rtl/trace_fifo.sv
// Synchronous record FIFO; pointers carry an extra wrap bit for full/empty detection.
module trace_fifo
    import trace_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                        clock,
    input  logic                        rst_n,
    input  logic                        push,
    input  logic                        pop,
    input  trace_rec_t                  din,
    output trace_rec_t                  dout,
    output logic                        full,
    output logic                        empty,
    output logic [$clog2(FIFO_DEPTH):0] level
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    trace_rec_t  r_mem [FIFO_DEPTH];
    logic [AW:0] r_wptr;
    logic [AW:0] r_rptr;
    logic        w_push_ok;
    logic        w_pop_ok;

    assign empty = (r_wptr == r_rptr);
    assign full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign level = r_wptr - r_rptr;
    assign dout  = r_mem[r_rptr[AW-1:0]];

    // A push into a full FIFO is still accepted when the head leaves in the same cycle
    assign w_pop_ok  = pop & ~empty;
    assign w_push_ok = push & (~full | w_pop_ok);

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push_ok) r_wptr <= r_wptr + 1'b1;
            if (w_pop_ok)  r_rptr <= r_rptr + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (w_push_ok) r_mem[r_wptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/exec_trace_tx.sv
// Trace transmitter: queues {pc,flags,result} records and sends each as two UART bytes.
// Define TRACE_PARITY_EN for 8E1 framing (adds an even-parity bit); default is 8N1.
module exec_trace_tx
    import trace_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned FIFO_DEPTH   = 8
) (
    input  logic                        clock,
    input  logic                        rst_n,
    input  logic                        en,
    input  logic                        sample,
    input  logic [2:0]                  pc,
    input  logic [1:0]                  flags,
    input  logic [3:0]                  result,
    output logic                        tx,
    output logic                        busy,
    output logic                        overflow,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

    localparam int unsigned BW = $clog2(CLKS_PER_BIT);

    tx_state_t   r_state;
    trace_rec_t  r_rec;
    logic [BW-1:0] r_baud;
    logic [2:0]  r_bit_idx;
    logic        r_byte_sel;
    logic        r_tx;
    logic        r_overflow;

    trace_rec_t  w_in;
    trace_rec_t  w_dout;
    logic        w_full;
    logic        w_empty;
    logic        w_push;
    logic        w_pop;
    logic        w_bit_done;
    logic [7:0]  w_byte;

    assign w_in       = trace_rec_t'({pc, flags, result});
    assign w_push     = sample & en;
    assign w_pop      = (r_state == IDLE) & ~w_empty;
    assign w_bit_done = (r_baud == BW'(CLKS_PER_BIT - 1));
    assign w_byte     = rec_byte(r_rec, r_byte_sel);

    trace_fifo #(
        .FIFO_DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clock(clock),
        .rst_n(rst_n),
        .push (w_push),
        .pop  (w_pop),
        .din  (w_in),
        .dout (w_dout),
        .full (w_full),
        .empty(w_empty),
        .level(fifo_level)
    );

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_rec      <= '0;
            r_baud     <= '0;
            r_bit_idx  <= '0;
            r_byte_sel <= 1'b0;
        end else begin
            if (r_state == IDLE || w_bit_done) r_baud <= '0;
            else                               r_baud <= r_baud + 1'b1;

            case (r_state)
                IDLE: begin
                    if (!w_empty) begin
                        r_rec      <= w_dout;
                        r_byte_sel <= 1'b0;
                        r_state    <= START;
                    end
                end
                START: begin
                    if (w_bit_done) begin
                        r_bit_idx <= '0;
                        r_state   <= DATA;
                    end
                end
                DATA: begin
                    if (w_bit_done) begin
                        r_bit_idx <= r_bit_idx + 3'd1;
`ifdef TRACE_PARITY_EN
                        if (r_bit_idx == 3'd7) r_state <= PARITY;
`else
                        if (r_bit_idx == 3'd7) r_state <= STOP;
`endif
                    end
                end
`ifdef TRACE_PARITY_EN
                PARITY: begin
                    if (w_bit_done) r_state <= STOP;
                end
`endif
                STOP: begin
                    if (w_bit_done) begin
                        if (!r_byte_sel) begin
                            r_byte_sel <= 1'b1;
                            r_state    <= START;
                        end else begin
                            r_state <= IDLE;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // tx is registered from the current state, lagging the FSM by one clock:
    // this gives the 2-cycle sample-to-start latency and one idle-high cycle between records.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_tx <= TX_IDLE;
        end else begin
            case (r_state)
                START:   r_tx <= 1'b0;
                DATA:    r_tx <= w_byte[r_bit_idx];
`ifdef TRACE_PARITY_EN
                PARITY:  r_tx <= ^w_byte;
`endif
                default: r_tx <= TX_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n)                          r_overflow <= 1'b0;
        else if (w_push & w_full & ~w_pop)   r_overflow <= 1'b1;
    end

    assign tx       = r_tx;
    assign overflow = r_overflow;
    assign busy     = (r_state != IDLE) | (fifo_level != '0);

endmodule

// File: tb/tb_exec_trace_tx.sv
// Self-checking bench for exec_trace_tx: directed tables, corner sequences and a random run vs a model.
module tb_exec_trace_tx;

    localparam int CPB   = 4;
    localparam int DEPTH = 8;
`ifdef TRACE_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif
    localparam int FRAME = 2 * FB * CPB;

    logic       clock = 1'b0;
    logic       rst_n;
    logic       en;
    logic       sample;
    logic [2:0] pc;
    logic [1:0] flags;
    logic [3:0] result;
    logic       tx;
    logic       busy;
    logic       overflow;
    logic [3:0] fifo_level;

    exec_trace_tx #(
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clock     (clock),
        .rst_n     (rst_n),
        .en        (en),
        .sample    (sample),
        .pc        (pc),
        .flags     (flags),
        .result    (result),
        .tx        (tx),
        .busy      (busy),
        .overflow  (overflow),
        .fifo_level(fifo_level)
    );

    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [2:0] pc;
        logic [1:0] fl;
        logic [3:0] res;
        logic [7:0] b0;
        logic [7:0] b1;
    } vec_t;
    vec_t tbl [4];

    // reference model state (random phase)
    logic [8:0] m_q [$];
    logic [8:0] m_cur;
    int         m_trem;
    int         m_o;
    bit         m_act;
    bit         m_ovf;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] enc0(input logic [8:0] r);
        return {3'b101, r[8:6], r[5:4]};
    endfunction

    function automatic logic [7:0] enc1(input logic [8:0] r);
        return {4'b0000, r[3:0]};
    endfunction

    function automatic logic exp_tx(input logic [8:0] r, input int o);
        int f, j;
        logic [7:0] b;
        if (o < 0 || o >= FRAME) return 1'b1;
        f = o / CPB;
        j = f % FB;
        b = (f < FB) ? enc0(r) : enc1(r);
        if (j == 0) return 1'b0;
        if (j <= 8) return b[j-1];
        if (FB == 11 && j == 9) return ^b;
        return 1'b1;
    endfunction

    // Host-side UART receiver: waits (bounded) for a start bit, samples mid-bit.
    task automatic rx_byte(output logic [7:0] b, output logic par, output logic stopb, output int waited);
        b = '0;
        par = 1'b0;
        stopb = 1'b0;
        waited = 0;
        while (tx !== 1'b0 && waited < 400) begin
            @(negedge clock);
            waited++;
        end
        @(negedge clock);
        for (int j = 0; j < 8; j++) begin
            repeat (CPB) @(negedge clock);
            b[j] = tx;
        end
        if (FB == 11) begin
            repeat (CPB) @(negedge clock);
            par = tx;
        end
        repeat (CPB) @(negedge clock);
        stopb = tx;
    endtask

    task automatic rx_check(input string tag, input logic [8:0] rec, output int w0);
        logic [7:0] b0, b1;
        logic p0, p1, s0, s1;
        int w1;
        rx_byte(b0, p0, s0, w0);
        rx_byte(b1, p1, s1, w1);
        chk({tag, " byte0"}, 32'(b0), 32'(enc0(rec)));
        chk({tag, " byte1"}, 32'(b1), 32'(enc1(rec)));
        chk({tag, " stop bits"}, 32'({s0, s1}), 32'(2'b11));
        chk({tag, " byte1 gap"}, 32'(w1), 32'(CPB - 1));
`ifdef TRACE_PARITY_EN
        chk({tag, " parity"}, 32'({p0, p1}), 32'({^enc0(rec), ^enc1(rec)}));
`endif
    endtask

    task automatic model_step(input bit se, input logic [8:0] rec);
        bit pop;
        pop = (m_trem == 0) && (m_q.size() > 0);
        if (pop) begin
            m_cur  = m_q.pop_front();
            m_trem = FRAME;
            m_o    = -1;
            m_act  = 1'b1;
        end else begin
            if (m_trem > 0) m_trem--;
            if (m_act) m_o++;
        end
        if (se) begin
            if (m_q.size() < DEPTH) m_q.push_back(rec);
            else                    m_ovf = 1'b1;
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        bit stay;
        logic [8:0] rec;
        logic [7:0] eb;
        logic exp_t;

        tbl[0] = '{3'd5, 2'b10, 4'hC, 8'hB6, 8'h0C};
        tbl[1] = '{3'd0, 2'b00, 4'h7, 8'hA0, 8'h07};
        tbl[2] = '{3'd7, 2'b11, 4'hF, 8'hBF, 8'h0F};
        tbl[3] = '{3'd2, 2'b01, 4'h0, 8'hA9, 8'h00};

        rst_n = 1'b0; en = 1'b0; sample = 1'b0; pc = '0; flags = '0; result = '0;
        repeat (3) @(negedge clock);
        chk("reset tx", 32'(tx), 32'd1);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset overflow", 32'(overflow), 32'd0);
        chk("reset level", 32'(fifo_level), 32'd0);
        rst_n = 1'b1;
        stay = 1'b1;
        repeat (50) begin
            @(negedge clock);
            if (tx !== 1'b1 || busy !== 1'b0) stay = 1'b0;
        end
        chk("idle after reset", 32'(stay), 32'd1);

        // table-driven single records
        en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            pc = tbl[i].pc; flags = tbl[i].fl; result = tbl[i].res; sample = 1'b1;
            @(negedge clock);
            sample = 1'b0;
            chk("single pushed level", 32'(fifo_level), 32'd1);
            rx_check("single", {tbl[i].pc, tbl[i].fl, tbl[i].res}, w);
            chk("single latency", 32'(w), 32'd2);
            chk("table byte0 const", 32'(enc0({tbl[i].pc, tbl[i].fl, tbl[i].res})), 32'(tbl[i].b0));
            chk("table byte1 const", 32'(enc1({tbl[i].pc, tbl[i].fl, tbl[i].res})), 32'(tbl[i].b1));
            @(negedge clock);
            chk("busy last cycle", 32'(busy), 32'd1);
            @(negedge clock);
            chk("busy after frame", 32'(busy), 32'd0);
            chk("tx after frame", 32'(tx), 32'd1);
        end

        // overflow: 10 back-to-back samples, the 10th is dropped
        fork
            begin
                for (int i = 0; i < 10; i++) begin
                    pc = i[2:0]; flags = i[1:0]; result = i[3:0]; sample = 1'b1;
                    @(negedge clock);
                end
                sample = 1'b0;
                chk("overflow set", 32'(overflow), 32'd1);
                chk("overflow level full", 32'(fifo_level), 32'(DEPTH));
            end
            begin
                for (int r = 0; r < 9; r++) begin
                    int wr;
                    rx_check("overflow rec", {r[2:0], r[1:0], r[3:0]}, wr);
                    chk("overflow rec gap", 32'(wr), (r == 0) ? 32'd3 : 32'(CPB));
                end
            end
        join
        repeat (2) @(negedge clock);
        chk("overflow drained busy", 32'(busy), 32'd0);
        chk("overflow drained level", 32'(fifo_level), 32'd0);
        chk("overflow sticky", 32'(overflow), 32'd1);

        // en gating
        en = 1'b0;
        stay = 1'b1;
        repeat (5) begin
            sample = 1'b1; @(negedge clock);
            sample = 1'b0; @(negedge clock);
            if (fifo_level !== 4'd0 || tx !== 1'b1 || busy !== 1'b0) stay = 1'b0;
        end
        chk("en=0 ignored", 32'(stay), 32'd1);
        fork
            begin
                en = 1'b1; pc = 3'd3; flags = 2'b01; result = 4'hA; sample = 1'b1;
                @(negedge clock);
                sample = 1'b0; en = 1'b0;
                repeat (20) @(negedge clock);
                pc = 3'd6; sample = 1'b1;
                @(negedge clock);
                sample = 1'b0;
                chk("en=0 mid-frame drop", 32'(fifo_level), 32'd0);
                repeat (10) @(negedge clock);
                en = 1'b1; pc = 3'd1; flags = 2'b10; result = 4'h5; sample = 1'b1;
                @(negedge clock);
                sample = 1'b0;
                chk("en=1 mid-frame queue", 32'(fifo_level), 32'd1);
            end
            begin
                int wa, wb;
                rx_check("en rec A", {3'd3, 2'b01, 4'hA}, wa);
                chk("en rec A gap", 32'(wa), 32'd3);
                rx_check("en rec B", {3'd1, 2'b10, 4'h5}, wb);
                chk("en rec B gap", 32'(wb), 32'(CPB));
            end
        join

        // reset mid-frame (during DATA bit 3 of byte0)
        repeat (4) @(negedge clock);
        rec = {3'd5, 2'b10, 4'hC};
        for (int i = 0; i < 3; i++) begin
            pc = 3'd5 + i[2:0]; flags = 2'b10; result = 4'hC; sample = 1'b1;
            @(negedge clock);
        end
        sample = 1'b0;
        repeat (17) @(negedge clock);
        eb = enc0(rec);
        chk("data bit3 before reset", 32'(tx), 32'(eb[3]));
        chk("level before reset", 32'(fifo_level), 32'd2);
        #2 rst_n = 1'b0;
        #1;
        chk("async reset tx", 32'(tx), 32'd1);
        chk("async reset level", 32'(fifo_level), 32'd0);
        chk("async reset busy", 32'(busy), 32'd0);
        chk("async reset overflow", 32'(overflow), 32'd0);
        repeat (3) @(negedge clock);
        rst_n = 1'b1;
        stay = 1'b1;
        repeat (150) begin
            @(negedge clock);
            if (tx !== 1'b1 || busy !== 1'b0) stay = 1'b0;
        end
        chk("no residual frame", 32'(stay), 32'd1);

        // randomized run against the reference model
        rst_n = 1'b0;
        repeat (2) @(negedge clock);
        rst_n = 1'b1;
        m_q.delete();
        m_trem = 0; m_o = 0; m_act = 1'b0; m_ovf = 1'b0; m_cur = '0;
        for (int c = 0; c < 4000; c++) begin
            int thresh;
            exp_t = m_act ? exp_tx(m_cur, m_o) : 1'b1;
            chk("random {tx,busy,ovf,level}",
                32'({tx, busy, overflow, fifo_level}),
                32'({exp_t, (m_trem > 0) || (m_q.size() > 0), m_ovf, 4'(m_q.size())}));
            case (c / 1000)
                0: thresh = 3;
                1: thresh = 15;
                2: thresh = 50;
                default: thresh = 2;
            endcase
            en     = ($urandom_range(0, 9) != 0);
            sample = ($urandom_range(0, 99) < thresh);
            pc     = 3'($urandom);
            flags  = 2'($urandom);
            result = 4'($urandom);
            model_step(en & sample, {pc, flags, result});
            @(negedge clock);
        end
        sample = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
